// File: rtl/out_accum_packer.sv
// Accumulates signed PE partial sums across input channels, requantises each entry to int8
// (optional ReLU) and streams the bytes out as little-endian AXI-Stream words.
module out_accum_packer #(
   parameter int NUM_PE  = 5,
   parameter int SUM_W   = 8,
   parameter int ACC_W   = 16,
   parameter int MAX_PIX = 64,
   parameter int SHIFT   = 4,
   parameter int OUT_W   = 32
) (
   input  logic                    m_axis_aclk,
   input  logic                    m_axis_areset,
   input  logic [NUM_PE*SUM_W-1:0] i_pe_sum,
   input  logic                    i_pe_sum_valid,
   input  logic                    i_ch_done,
   input  logic                    i_out_done,
   input  logic                    i_frame_last,
   input  logic                    i_relu_en,
   output logic                    o_in_ready,
   output logic                    o_overflow,
   output logic                    m_axis_tvalid,
   output logic [OUT_W-1:0]        m_axis_tdata,
   output logic [OUT_W/8-1:0]      m_axis_tstrb,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready
);

   localparam int LANES   = OUT_W / 8;
   localparam int IDX_W   = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
   localparam int PTR_W   = IDX_W + 1;
   localparam int PE_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int BYTES_W = $clog2(MAX_PIX * NUM_PE + 1);
   localparam int CH_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] x);
      logic [ACC_W-1:0] r;
      if (x[ACC_W] != x[ACC_W-1]) begin
         r = x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         r = x[ACC_W-1:0];
      end
      return r;
   endfunction

   function automatic logic [7:0] requant(input logic [ACC_W-1:0] a, input logic relu);
      logic signed [ACC_W-1:0] v;
      logic signed [ACC_W-1:0] s;
      logic [7:0]              q;
      v = (relu && a[ACC_W-1]) ? '0 : $signed(a);
      s = v >>> SHIFT;
      if ((s[ACC_W-1:7] == '0) || (s[ACC_W-1:7] == '1)) begin
         q = s[7:0];
      end else begin
         q = s[ACC_W-1] ? 8'h80 : 8'h7F;
      end
      return q;
   endfunction

   state_t                 state_r, state_nx_s;
   logic [ACC_W-1:0]       acc_mem_r [MAX_PIX][NUM_PE];
   logic [ACC_W-1:0]       acc_nx_s [NUM_PE];
   logic [PTR_W-1:0]       wr_ptr_r, wr_ptr_inc_s;
   logic [CH_W-1:0]        ch_cnt_r;
   logic [BYTES_W-1:0]     bytes_left_r;
   logic [PTR_W-1:0]       rd_e_r;
   logic [PE_W-1:0]        rd_p_r;
   logic                   frame_last_r, last_word_r, overflow_r, in_ready_r;
   logic                   tvalid_r, tlast_r;
   logic [OUT_W-1:0]       tdata_r;
   logic [LANES-1:0]       tstrb_r;

   logic                   in_phase_s, beat_in_s, beat_ok_s, beat_drop_s, chd_s, drain_go_s;
   logic                   load_s, drain_done_s;
   logic [OUT_W-1:0]       pack_data_s;
   logic [LANES-1:0]       pack_strb_s;
   logic                   pack_last_s;
   logic [PTR_W-1:0]       pack_e_s;
   logic [PE_W-1:0]        pack_p_s;
   logic [BYTES_W-1:0]     pack_left_s;

   assign in_phase_s   = (state_r != ST_DRAIN);
   assign beat_in_s    = in_phase_s && i_pe_sum_valid;
   assign beat_drop_s  = beat_in_s && (wr_ptr_r == PTR_W'(MAX_PIX));
   assign beat_ok_s    = beat_in_s && !beat_drop_s;
   assign chd_s        = in_phase_s && i_ch_done;
   assign drain_go_s   = chd_s && i_out_done;
   assign wr_ptr_inc_s = wr_ptr_r + PTR_W'(beat_ok_s);
   assign load_s       = (state_r == ST_DRAIN) && (bytes_left_r != '0) && (!tvalid_r || m_axis_tready);
   assign drain_done_s = (state_r == ST_DRAIN) &&
                         ((tvalid_r && m_axis_tready && last_word_r) || (!tvalid_r && (bytes_left_r == '0)));

   // State register
   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (drain_go_s) begin
               state_nx_s = ST_DRAIN;
            end else if (beat_ok_s) begin
               state_nx_s = ST_ACCUM;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (drain_go_s) begin
               state_nx_s = ST_DRAIN;
            end else begin
               state_nx_s = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            if (drain_done_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Read-modify-write value: first channel overwrites, later channels add with saturation
   always_comb begin
      for (int k = 0; k < NUM_PE; k++) begin
         logic [SUM_W-1:0] s;
         logic [ACC_W-1:0] sx;
         logic [ACC_W-1:0] rd;
         s  = i_pe_sum[k*SUM_W +: SUM_W];
         sx = {{(ACC_W-SUM_W){s[SUM_W-1]}}, s};
         rd = acc_mem_r[wr_ptr_r[IDX_W-1:0]][k];
         if (ch_cnt_r == '0) begin
            acc_nx_s[k] = sx;
         end else begin
            acc_nx_s[k] = sat_acc({rd[ACC_W-1], rd} + {sx[ACC_W-1], sx});
         end
      end
   end

   // Accumulator storage write port
   always_ff @(posedge m_axis_aclk) begin
      if (beat_ok_s) begin
         for (int k = 0; k < NUM_PE; k++) begin
            acc_mem_r[wr_ptr_r[IDX_W-1:0]][k] <= acc_nx_s[k];
         end
      end
   end

   // Gather the next LANES bytes of the drain stream, walking entries then PEs
   always_comb begin
      logic [PTR_W-1:0] e;
      logic [PE_W-1:0]  p;
      e           = rd_e_r;
      p           = rd_p_r;
      pack_data_s = '0;
      pack_strb_s = '0;
      for (int l = 0; l < LANES; l++) begin
         if (BYTES_W'(l) < bytes_left_r) begin
            pack_data_s[l*8 +: 8] = requant(acc_mem_r[e[IDX_W-1:0]][p], i_relu_en);
            pack_strb_s[l]        = 1'b1;
            if (p == PE_W'(NUM_PE - 1)) begin
               p = '0;
               e = e + 1'b1;
            end else begin
               p = p + 1'b1;
            end
         end else begin
            pack_strb_s[l] = 1'b0;
         end
      end
      pack_e_s    = e;
      pack_p_s    = p;
      pack_last_s = (bytes_left_r <= BYTES_W'(LANES));
      pack_left_s = pack_last_s ? '0 : (bytes_left_r - BYTES_W'(LANES));
   end

   // Pointers, channel bookkeeping and the registered output stage
   always_ff @(posedge m_axis_aclk) begin
      if (m_axis_areset) begin
         wr_ptr_r     <= '0;
         ch_cnt_r     <= '0;
         bytes_left_r <= '0;
         rd_e_r       <= '0;
         rd_p_r       <= '0;
         frame_last_r <= 1'b0;
         last_word_r  <= 1'b0;
         overflow_r   <= 1'b0;
         in_ready_r   <= 1'b1;
         tvalid_r     <= 1'b0;
         tdata_r      <= '0;
         tstrb_r      <= '0;
         tlast_r      <= 1'b0;
      end else begin
         in_ready_r <= (state_nx_s != ST_DRAIN);
         if (beat_drop_s) begin
            overflow_r <= 1'b1;
         end
         if (in_phase_s) begin
            if (chd_s) begin
               wr_ptr_r <= '0;
               if (ch_cnt_r != '1) begin
                  ch_cnt_r <= ch_cnt_r + 1'b1;
               end
            end else begin
               wr_ptr_r <= wr_ptr_inc_s;
            end
            if (drain_go_s) begin
               frame_last_r <= i_frame_last;
               bytes_left_r <= BYTES_W'(wr_ptr_inc_s) * BYTES_W'(NUM_PE);
               rd_e_r       <= '0;
               rd_p_r       <= '0;
            end
         end
         if (load_s) begin
            tvalid_r     <= 1'b1;
            tdata_r      <= pack_data_s;
            tstrb_r      <= pack_strb_s;
            tlast_r      <= pack_last_s && frame_last_r;
            last_word_r  <= pack_last_s;
            bytes_left_r <= pack_left_s;
            rd_e_r       <= pack_e_s;
            rd_p_r       <= pack_p_s;
         end else if (tvalid_r && m_axis_tready) begin
            tvalid_r    <= 1'b0;
            tdata_r     <= '0;
            tstrb_r     <= '0;
            tlast_r     <= 1'b0;
            last_word_r <= 1'b0;
         end
         if (drain_done_s) begin
            ch_cnt_r <= '0;
            wr_ptr_r <= '0;
         end
      end
   end

   assign o_in_ready    = in_ready_r;
   assign o_overflow    = overflow_r;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tdata  = tdata_r;
   assign m_axis_tstrb  = tstrb_r;
   assign m_axis_tlast  = tlast_r;

endmodule
